// File: rtl/rd_req_exec_s.sv
// rd_req_exec_s: slow-domain read-request executor.
// Counts incoming read-request pulses and issues one fixed-latency memory read per
// request at an auto-incrementing, wrapping address. Each returned word goes into a
// 3-entry output FIFO drained by a valid/ready stream. A credit check on issue keeps
// the FIFO from overflowing, so back-pressure never loses data.
// Ports:
//   clk_s, rst_s   clock, synchronous active-high reset
//   rd_en_i        one-cycle read-request pulse
//   mem_rd_o       memory read strobe
//   mem_addr_o     memory read address
//   mem_dat_i      read data, one cycle after mem_rd_o
//   dat_o, vld_o   output stream data / valid (FIFO head)
//   rdy_i          output stream ready
//   pend_o         pending-request count (saturating)
//   ovf_o          sticky flag: a request was dropped at saturation
module rd_req_exec_s #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 4,
  parameter int unsigned CW = 4
) (
  input  logic          clk_s,
  input  logic          rst_s,
  input  logic          rd_en_i,
  output logic          mem_rd_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic [DW-1:0] mem_dat_i,
  output logic [DW-1:0] dat_o,
  output logic          vld_o,
  input  logic          rdy_i,
  output logic [CW-1:0] pend_o,
  output logic          ovf_o
);

  localparam logic [CW-1:0] PendMax = '1;

  logic [CW-1:0] r_pend;
  logic [AW-1:0] r_addr;
  logic          r_inflight;
  logic          r_ovf;
  logic [DW-1:0] r_buf [3];
  logic [1:0]    r_rd_ptr;
  logic [1:0]    r_wr_ptr;
  logic [1:0]    r_occ;

  logic [CW-1:0] w_pend_d;
  logic          w_ovf_d;
  logic [2:0]    w_credit;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;

  // Words already committed to the FIFO: stored plus the one still returning.
  assign w_credit = {1'b0, r_occ} + {2'b00, r_inflight};
  assign w_issue  = (r_pend != '0) && (w_credit < 3'd3);
  assign w_push   = r_inflight;
  assign w_pop    = vld_o & rdy_i;

  always_comb begin
    w_pend_d = r_pend;
    w_ovf_d  = r_ovf;
    case ({rd_en_i, w_issue})
      2'b10: begin
        if (r_pend == PendMax) begin
          w_ovf_d = 1'b1;
        end else begin
          w_pend_d = r_pend + 1'b1;
        end
      end
      2'b01:   w_pend_d = r_pend - 1'b1;
      default: ; // idle, or request and issue cancel out
    endcase
  end

  always_ff @(posedge clk_s) begin
    if (rst_s) begin
      r_pend     <= '0;
      r_addr     <= '0;
      r_inflight <= 1'b0;
      r_ovf      <= 1'b0;
      r_rd_ptr   <= 2'd0;
      r_wr_ptr   <= 2'd0;
      r_occ      <= 2'd0;
    end else begin
      r_pend     <= w_pend_d;
      r_ovf      <= w_ovf_d;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_addr <= r_addr + 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == 2'd2) ? 2'd0 : r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == 2'd2) ? 2'd0 : r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: pointers are reset and dat_o is gated by vld_o.
  always_ff @(posedge clk_s) begin
    if (w_push) begin
      r_buf[r_wr_ptr] <= mem_dat_i;
    end
  end

  assign mem_rd_o   = w_issue;
  assign mem_addr_o = r_addr;
  assign vld_o      = (r_occ != 2'd0);
  assign dat_o      = vld_o ? r_buf[r_rd_ptr] : '0;
  assign pend_o     = r_pend;
  assign ovf_o      = r_ovf;

endmodule

// File: tb/tb_rd_req_exec_s.sv
// Testbench for rd_req_exec_s: directed steps with a data scoreboard.
// Expected words (addr + 0x100) are queued when requests are driven and popped as the
// DUT transfers words; issued addresses are checked against a wrapping counter.
module tb_rd_req_exec_s;

  logic        clk_s = 1'b0;
  logic        rst_s;
  logic        rd_en_i;
  logic        mem_rd_o;
  logic [3:0]  mem_addr_o;
  logic [31:0] mem_dat_i;
  logic [31:0] dat_o;
  logic        vld_o;
  logic        rdy_i;
  logic [3:0]  pend_o;
  logic        ovf_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_issue = 0;
  int          n_words = 0;
  logic [3:0]  exp_req_addr = 4'd0;
  logic [3:0]  exp_iss_addr = 4'd0;
  logic [31:0] exp_q [$];

  rd_req_exec_s #(.DW(32), .AW(4), .CW(4)) dut (
    .clk_s      (clk_s),
    .rst_s      (rst_s),
    .rd_en_i    (rd_en_i),
    .mem_rd_o   (mem_rd_o),
    .mem_addr_o (mem_addr_o),
    .mem_dat_i  (mem_dat_i),
    .dat_o      (dat_o),
    .vld_o      (vld_o),
    .rdy_i      (rdy_i),
    .pend_o     (pend_o),
    .ovf_o      (ovf_o)
  );

  always #5 clk_s = ~clk_s;

  // Memory model: one-cycle latency, junk when no read was issued.
  always @(posedge clk_s) begin
    mem_dat_i <= mem_rd_o ? 32'h100 + 32'(mem_addr_o) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitors sample on the falling edge.
  always @(negedge clk_s) begin
    if (!rst_s) begin
      if (mem_rd_o) begin
        chk("issue_addr", 32'(mem_addr_o), 32'(exp_iss_addr));
        exp_iss_addr = exp_iss_addr + 4'd1;
        n_issue++;
      end
      if (vld_o && rdy_i) begin
        n_words++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $error("FAIL dat_unexpected: observed %0h expected no word", dat_o);
        end else begin
          chk("dat_order", dat_o, exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_s);
    #1;
  endtask

  task automatic do_reset();
    rst_s = 1'b1;
    tick();
    rst_s = 1'b0;
    exp_q.delete();
    exp_req_addr = 4'd0;
    exp_iss_addr = 4'd0;
  endtask

  task automatic pulse(input bit accept);
    rd_en_i = 1'b1;
    if (accept) begin
      exp_q.push_back(32'h100 + 32'(exp_req_addr));
      exp_req_addr = exp_req_addr + 4'd1;
    end
    tick();
    rd_en_i = 1'b0;
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    tick();
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem_rd"}, 32'(mem_rd_o), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr_o), 32'd0);
    chk({tag, "_vld"}, 32'(vld_o), 32'd0);
    chk({tag, "_dat"}, dat_o, 32'd0);
    chk({tag, "_pend"}, 32'(pend_o), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf_o), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int words0;
    int iss0;
    rst_s   = 1'b1;
    rd_en_i = 1'b0;
    rdy_i   = 1'b1;
    tick();
    tick();
    do_reset();
    chk_reset_vals("rst");

    // Single request: N+1 issue, N+2 pend back to 0, N+3 valid.
    repeat (8) tick();
    pulse(1'b1);
    chk("single_pend1", 32'(pend_o), 32'd1);
    chk("single_rd", 32'(mem_rd_o), 32'd1);
    chk("single_addr", 32'(mem_addr_o), 32'd0);
    tick();
    chk("single_pend0", 32'(pend_o), 32'd0);
    chk("single_vld0", 32'(vld_o), 32'd0);
    tick();
    chk("single_vld1", 32'(vld_o), 32'd1);
    chk("single_dat", dat_o, 32'h100);
    drain("single_drain", 10);

    // Burst of 20 with address wrap; each word valid exactly 3 cycles after its pulse.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      pulse(1'b1);
      if (i > 0) chk("burst_vld", 32'(vld_o), 32'd1);
      tick();
    end
    tick();
    chk("burst_vld_last", 32'(vld_o), 32'd1);
    drain("burst_drain", 10);
    chk("burst_ovf", 32'(ovf_o), 32'd0);
    chk("burst_next_addr", 32'(mem_addr_o), 32'd4);

    // Back-pressure: only 3 reads outstanding, the rest stay pending.
    rdy_i  = 1'b0;
    iss0   = n_issue;
    words0 = n_words;
    for (int i = 0; i < 8; i++) begin
      pulse(1'b1);
      tick();
    end
    chk("bp_issued", 32'(n_issue - iss0), 32'd3);
    chk("bp_pend", 32'(pend_o), 32'd5);
    chk("bp_vld", 32'(vld_o), 32'd1);
    chk("bp_head", dat_o, exp_q[0]);
    tick();
    tick();
    chk("bp_head_stable", dat_o, exp_q[0]);
    chk("bp_no_issue", 32'(mem_rd_o), 32'd0);
    rdy_i = 1'b1;
    drain("bp_drain", 40);
    chk("bp_words", 32'(n_words - words0), 32'd8);
    chk("bp_pend_end", 32'(pend_o), 32'd0);

    // Overflow: 20 pulses under back-pressure, last 2 dropped.
    do_reset();
    rdy_i  = 1'b0;
    words0 = n_words;
    for (int i = 0; i < 18; i++) begin
      pulse(1'b1);
      tick();
    end
    chk("ovf_pend15", 32'(pend_o), 32'd15);
    chk("ovf_not_yet", 32'(ovf_o), 32'd0);
    pulse(1'b0);
    tick();
    pulse(1'b0);
    tick();
    chk("ovf_pend_sat", 32'(pend_o), 32'd15);
    chk("ovf_set", 32'(ovf_o), 32'd1);
    rdy_i = 1'b1;
    drain("ovf_drain", 60);
    repeat (4) tick();
    chk("ovf_words", 32'(n_words - words0), 32'd18);
    chk("ovf_pend_end", 32'(pend_o), 32'd0);
    chk("ovf_sticky", 32'(ovf_o), 32'd1);

    // Request and issue together at saturation: count holds, no overflow.
    do_reset();
    chk("sat_ovf_cleared", 32'(ovf_o), 32'd0);
    rdy_i = 1'b0;
    for (int i = 0; i < 18; i++) begin
      pulse(1'b1);
      tick();
    end
    chk("sat_pend15", 32'(pend_o), 32'd15);
    rdy_i = 1'b1;
    tick();
    rdy_i = 1'b0;
    chk("sat_issue", 32'(mem_rd_o), 32'd1);
    pulse(1'b1);
    chk("sat_pend_hold", 32'(pend_o), 32'd15);
    chk("sat_ovf_clear", 32'(ovf_o), 32'd0);
    rdy_i = 1'b1;
    drain("sat_drain", 60);
    chk("sat_pend_end", 32'(pend_o), 32'd0);

    // Reset in the cycle after the read strobe: returning word is discarded.
    pulse(1'b1);
    chk("mid_rd", 32'(mem_rd_o), 32'd1);
    tick();
    rst_s = 1'b1;
    tick();
    rst_s = 1'b0;
    exp_q.delete();
    exp_req_addr = 4'd0;
    exp_iss_addr = 4'd0;
    chk_reset_vals("mid");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_vld", 32'(vld_o), 32'd0);
    end

    // Reset during the read strobe: data returns with nothing in flight.
    pulse(1'b1);
    chk("mid2_rd", 32'(mem_rd_o), 32'd1);
    do_reset();
    chk_reset_vals("mid2");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid2_no_vld", 32'(vld_o), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
